stream_accumulator: RTL

STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

---
 rtl/stream_accumulator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stream_accumulator.sv
// Sums LANES unsigned lanes per accepted AXI-Stream beat across a transaction and
// returns sum, beat count and sticky overflow through a valid/ready response port.
module stream_accumulator #(
    parameter int DATAW          = 64,
    parameter int LANES          = 4,
    parameter int AXIS_MAX_DATAW = 512,
    parameter int CNTW           = 16,
    parameter int SATURATE       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axis_adder_interface_tvalid,
    input  logic                      axis_adder_interface_tlast,
    input  logic [AXIS_MAX_DATAW-1:0] axis_adder_interface_tdata,
    output logic                      axis_adder_interface_tready,
    output logic [DATAW-1:0]          response,
    output logic [CNTW-1:0]           response_count,
    output logic                      response_overflow,
    output logic                      response_valid,
    input  logic                      response_ready
);

    // Wide enough that acc + LANES full-scale lanes can never overflow internally.
    localparam int SUMW = DATAW + $clog2(LANES + 1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        RESP  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DATAW-1:0]  acc_r;
    logic [DATAW-1:0]  acc_s;
    logic [CNTW-1:0]   cnt_r;
    logic [CNTW-1:0]   cnt_s;
    logic              ovf_r;
    logic              ovf_s;
    logic              tready_r;
    logic              valid_r;
    logic [SUMW-1:0]   sum_s;
    logic              carry_s;
    logic              beat_s;
    logic              unused_tdata_s;

    // Lanes above LANES*DATAW are intentionally ignored.
    assign unused_tdata_s = ^axis_adder_interface_tdata;

    assign beat_s = axis_adder_interface_tvalid & tready_r;

    // Single-cycle adder tree: accumulator plus every lane of the current beat.
    always_comb begin
        sum_s = {{(SUMW-DATAW){1'b0}}, acc_r};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + {{(SUMW-DATAW){1'b0}}, axis_adder_interface_tdata[i*DATAW +: DATAW]};
        end
        carry_s = |sum_s[SUMW-1:DATAW];
    end

    // Next-state, accumulator, counter and overflow-flag update.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        case (state_r)
            ACCUM: begin
                if (beat_s) begin
                    if ((SATURATE != 0) && carry_s) begin
                        acc_s = {DATAW{1'b1}};
                    end else begin
                        acc_s = sum_s[DATAW-1:0];
                    end
                    if (&cnt_r) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                    end
                    ovf_s = ovf_r | carry_s;
                    if (axis_adder_interface_tlast) begin
                        state_s = RESP;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            RESP: begin
                if (response_ready) begin
                    state_s = ACCUM;
                    acc_s   = {DATAW{1'b0}};
                    cnt_s   = {CNTW{1'b0}};
                    ovf_s   = 1'b0;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = ACCUM;
            end
        endcase
    end

    // State and output registers; handshake outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ACCUM;
            acc_r    <= {DATAW{1'b0}};
            cnt_r    <= {CNTW{1'b0}};
            ovf_r    <= 1'b0;
            tready_r <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            ovf_r    <= ovf_s;
            tready_r <= (state_s == ACCUM);
            valid_r  <= (state_s == RESP);
        end
    end

    assign axis_adder_interface_tready = tready_r;
    assign response                    = acc_r;
    assign response_count              = cnt_r;
    assign response_overflow           = ovf_r;
    assign response_valid              = valid_r;

endmodule
